// File: rtl/booth_r4_mult_pipe_if.sv
// rtl/booth_r4_mult_pipe_if.sv - operand/result stream interface for booth_r4_mult_pipe
interface booth_r4_mult_pipe_if #(
    parameter int DATAWIDTH = 8,
    parameter int TAGWIDTH  = 4
);
    // Operand stream
    logic                     IN_VALID;
    logic                     IN_READY;
    logic [DATAWIDTH-1:0]     IN_A;
    logic [DATAWIDTH-1:0]     IN_B;
    logic                     IN_SIGNED;
    logic [TAGWIDTH-1:0]      IN_TAG;

    // Result stream
    logic                     OUT_VALID;
    logic                     OUT_READY;
    logic [2*DATAWIDTH-1:0]   OUT_RESULT;
    logic [TAGWIDTH-1:0]      OUT_TAG;

    // Operand-fetch / accumulator side
    modport master (
        output IN_VALID, IN_A, IN_B, IN_SIGNED, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_RESULT, OUT_TAG
    );

    // Multiplier side
    modport slave (
        input  IN_VALID, IN_A, IN_B, IN_SIGNED, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, OUT_RESULT, OUT_TAG
    );
endinterface

// File: rtl/booth_r4_mult_pipe.sv
// rtl/booth_r4_mult_pipe.sv - pipelined radix-4 Booth multiplier, optional BOOTH_R4_BACKPRESSURE_EN
module booth_r4_mult_pipe #(
    parameter int DATAWIDTH = 8,
    parameter int TAGWIDTH  = 4
) (
    input  logic               CLK,
    input  logic               RSTn,
    booth_r4_mult_pipe_if.slave bus
);
    localparam int W  = DATAWIDTH;
    localparam int WE = W + 2;          // extended operand width
    localparam int SW = 2 * W + 2;      // partial sum width
    localparam int ND = W / 2 + 1;      // Booth digits == pipeline stages
    localparam int TW = TAGWIDTH;

    // Stage k holds a transaction with digits 0..k-1 already applied.
    logic [ND-1:0] st_valid_q;
    logic [SW-1:0] st_sum_q  [ND];
    logic [WE-1:0] st_a_q    [ND];
    logic [WE-1:0] st_b_q    [ND];      // remaining multiplier bits, LSBs are the next digit
    logic [ND-1:0] st_bm1_q;            // bit just below the current digit
    logic [TW-1:0] st_tag_q  [ND];
    logic [SW-1:0] st_sum_d  [ND];

    logic              out_valid_q;
    logic [2*W-1:0]    out_result_q;
    logic [TW-1:0]     out_tag_q;

    logic          stall;
    logic          advance;
    logic          accept;
    logic [WE-1:0] in_a_ext;
    logic [WE-1:0] in_b_ext;

`ifdef BOOTH_R4_BACKPRESSURE_EN
    // A result waiting on downstream freezes the whole pipe.
    assign stall = out_valid_q & ~bus.OUT_READY;
`else
    // Downstream always sinks results, so the pipe never stops.
    logic unused_out_ready;
    assign unused_out_ready = bus.OUT_READY;
    assign stall            = 1'b0;
`endif

    assign advance      = ~stall;
    assign accept       = bus.IN_VALID & advance;
    assign bus.IN_READY = advance;

    assign in_a_ext = {{2{bus.IN_SIGNED & bus.IN_A[W-1]}}, bus.IN_A};
    assign in_b_ext = {{2{bus.IN_SIGNED & bus.IN_B[W-1]}}, bus.IN_B};

    assign bus.OUT_VALID  = out_valid_q;
    assign bus.OUT_RESULT = out_result_q;
    assign bus.OUT_TAG    = out_tag_q;

    // Recode each stage's digit and add its weighted partial product.
    always_comb begin
        logic [SW-1:0] a_sx;
        logic [SW-1:0] pp;
        a_sx = '0;
        pp   = '0;
        for (int k = 0; k < ND; k++) begin
            a_sx = {{(SW-WE){st_a_q[k][WE-1]}}, st_a_q[k]};
            case ({st_b_q[k][1:0], st_bm1_q[k]})
                3'b001, 3'b010: pp = a_sx;
                3'b011:         pp = a_sx << 1;
                3'b100:         pp = -(a_sx << 1);
                3'b101, 3'b110: pp = -a_sx;
                default:        pp = '0;
            endcase
            st_sum_d[k] = st_sum_q[k] + (pp << (2 * k));
        end
    end

    // Stage datapath registers; contents only matter where the valid bit is set.
    always_ff @(posedge CLK) begin
        if (advance) begin
            if (accept) begin
                st_sum_q[0] <= '0;
                st_a_q[0]   <= in_a_ext;
                st_b_q[0]   <= in_b_ext;
                st_bm1_q[0] <= 1'b0;
                st_tag_q[0] <= bus.IN_TAG;
            end
            for (int k = 1; k < ND; k++) begin
                if (st_valid_q[k-1]) begin
                    st_sum_q[k] <= st_sum_d[k-1];
                    st_a_q[k]   <= st_a_q[k-1];
                    st_b_q[k]   <= {{2{st_b_q[k-1][WE-1]}}, st_b_q[k-1][WE-1:2]};
                    st_bm1_q[k] <= st_b_q[k-1][1];
                    st_tag_q[k] <= st_tag_q[k-1];
                end
            end
        end
    end

    // Valid chain and output register; output holds whenever no new result lands.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            st_valid_q   <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (advance) begin
            st_valid_q  <= {st_valid_q[ND-2:0], accept};
            out_valid_q <= st_valid_q[ND-1];
            if (st_valid_q[ND-1]) begin
                out_result_q <= st_sum_d[ND-1][2*W-1:0];
                out_tag_q    <= st_tag_q[ND-1];
            end
        end
    end
endmodule
